// File: rtl/inst_buffer.sv
// Instruction buffer: circular FIFO between pre-decode and decode with ibuf_full backpressure.
// Optional macro IBUF_BYPASS_EN forwards the incoming block straight to decode when the buffer is empty.
module inst_buffer #(
    parameter int unsigned BLOCK_INST_SIZE = 8,
    parameter int unsigned DECODE_WIDTH    = 4,
    parameter int unsigned IBUF_DEPTH      = 32,
    parameter int unsigned FSQ_WIDTH       = 4,
    parameter int unsigned PRED_WIDTH      = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [BLOCK_INST_SIZE-1:0]            in_en,
    input  logic [$clog2(BLOCK_INST_SIZE):0]      in_num,
    input  logic [BLOCK_INST_SIZE*32-1:0]         in_inst,
    input  logic [BLOCK_INST_SIZE*PRED_WIDTH-1:0] in_offset,
    input  logic [FSQ_WIDTH-1:0]                  in_fsq_idx,
    input  logic                                  in_ipf,
    input  logic                                  in_iam,
    input  logic                                  flush,
    output logic                                  ibuf_full,
    output logic [DECODE_WIDTH-1:0]               out_valid,
    input  logic                                  out_ready,
    output logic [DECODE_WIDTH*32-1:0]            out_inst,
    output logic [DECODE_WIDTH*PRED_WIDTH-1:0]    out_offset,
    output logic [DECODE_WIDTH*FSQ_WIDTH-1:0]     out_fsq_idx,
    output logic [DECODE_WIDTH*2-1:0]             out_exc,
    output logic [$clog2(IBUF_DEPTH):0]           count
);
    localparam int unsigned PW = $clog2(IBUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NW = $clog2(BLOCK_INST_SIZE) + 1;

    typedef struct packed {
        logic [31:0]           inst;
        logic [PRED_WIDTH-1:0] offset;
        logic [FSQ_WIDTH-1:0]  fsq_idx;
        logic                  ipf;
        logic                  iam;
    } entry_t;

    entry_t        mem_q [IBUF_DEPTH];
    entry_t        in_ent [BLOCK_INST_SIZE];
    entry_t        out_ent [DECODE_WIDTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] wr_num;
    logic [CW-1:0] deq;
    logic          wr;

    assign ibuf_full = count_q > CW'(IBUF_DEPTH - BLOCK_INST_SIZE);
    assign wr        = in_en[0] & ~ibuf_full & ~flush;
    assign wr_num    = wr ? CW'(in_num) : '0;
    assign count     = count_q;

    // Unpack the incoming block; fsq index and exception flags are shared by every slot.
    always_comb begin
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            in_ent[i].inst    = in_inst[32*i +: 32];
            in_ent[i].offset  = in_offset[PRED_WIDTH*i +: PRED_WIDTH];
            in_ent[i].fsq_idx = in_fsq_idx;
            in_ent[i].ipf     = in_ipf;
            in_ent[i].iam     = in_iam;
        end
    end

    // Head window for decode; deq counts the slots consumed when decode is ready.
    always_comb begin
        deq = '0;
        for (int i = 0; i < DECODE_WIDTH; i++) begin
            out_ent[i]   = mem_q[head_q + PW'(i)];
            out_valid[i] = CW'(i) < count_q;
`ifdef IBUF_BYPASS_EN
            if (wr && (count_q == '0)) begin
                out_ent[i]   = in_ent[i];
                out_valid[i] = NW'(i) < in_num;
            end
`endif
            if (out_ready && out_valid[i]) begin
                deq = deq + CW'(1);
            end
            out_inst[32*i +: 32]                 = out_ent[i].inst;
            out_offset[PRED_WIDTH*i +: PRED_WIDTH] = out_ent[i].offset;
            out_fsq_idx[FSQ_WIDTH*i +: FSQ_WIDTH]  = out_ent[i].fsq_idx;
            out_exc[2*i +: 2]                    = {out_ent[i].iam, out_ent[i].ipf};
        end
    end

    // Bypassed instructions are still written to storage; head skips over them, so count holds only the remainder.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PW'(deq);
            tail_d  = tail_q + PW'(wr_num);
            count_d = count_q + wr_num - deq;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
            if (wr && (NW'(i) < in_num)) begin
                mem_q[tail_q + PW'(i)] <= in_ent[i];
            end
        end
    end

    a_num_matches_mask: assert property (@(posedge clk) disable iff (!rst)
        in_en[0] |-> ($countones(in_en) == int'(in_num)));
    a_count_bound: assert property (@(posedge clk) disable iff (!rst)
        count_q <= CW'(IBUF_DEPTH));
    a_no_write_full: assert property (@(posedge clk) disable iff (!rst)
        !(wr && ibuf_full));
endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer: directed vector table, hand sequences and a queue-based reference model.
module tb_inst_buffer;
    localparam int unsigned BIS = 8;
    localparam int unsigned DW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    in_en;
    logic [3:0]    in_num;
    logic [255:0]  in_inst;
    logic [31:0]   in_offset;
    logic [3:0]    in_fsq_idx;
    logic          in_ipf, in_iam, flush, out_ready;
    logic          ibuf_full;
    logic [3:0]    out_valid;
    logic [127:0]  out_inst;
    logic [15:0]   out_offset;
    logic [15:0]   out_fsq_idx;
    logic [7:0]    out_exc;
    logic [5:0]    count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] inst;
        logic [3:0]  off;
        logic [3:0]  fsq;
        logic        ipf;
        logic        iam;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        int          n;
        logic        fl;
        logic        rdy;
        logic [31:0] base;
        int          exp_cnt;
        logic        exp_full;
    } vec_t;
    vec_t vt[$];

    inst_buffer dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_num(in_num), .in_inst(in_inst),
        .in_offset(in_offset), .in_fsq_idx(in_fsq_idx), .in_ipf(in_ipf), .in_iam(in_iam),
        .flush(flush), .ibuf_full(ibuf_full), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_offset(out_offset), .out_fsq_idx(out_fsq_idx),
        .out_exc(out_exc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int n, input logic [31:0] base, input logic fl, input logic rdy, input bit rnd);
        in_num     = 4'(n);
        in_en      = 8'((1 << n) - 1);
        flush      = fl;
        out_ready  = rdy;
        in_fsq_idx = rnd ? 4'($urandom) : 4'd5;
        in_ipf     = rnd ? 1'($urandom) : 1'b0;
        in_iam     = rnd ? 1'($urandom) : 1'b0;
        for (int i = 0; i < BIS; i++) begin
            in_inst[32*i +: 32] = rnd ? 32'($urandom) : base + 32'(i);
            in_offset[4*i +: 4] = rnd ? 4'($urandom) : 4'(i);
        end
    endtask

    // Compare against the model's view of the buffer, then advance the model by one clock.
    task automatic check_cycle();
        int          sz;
        int          n;
        int          k;
        bit          mfull;
        bit          mwr;
        bit          byp;
        logic [3:0]  ev;
        ent_t        exp_e [DW];
        ent_t        e;
        sz    = mq.size();
        n     = int'(in_num);
        mfull = sz > 24;
        mwr   = in_en[0] && !mfull && !flush;
        byp   = 1'b0;
`ifdef IBUF_BYPASS_EN
        byp = mwr && (sz == 0);
`endif
        for (int i = 0; i < DW; i++) begin
            exp_e[i] = '{32'd0, 4'd0, 4'd0, 1'b0, 1'b0};
            if (byp) begin
                ev[i] = i < n;
                exp_e[i] = '{in_inst[32*i +: 32], in_offset[4*i +: 4], in_fsq_idx, in_ipf, in_iam};
            end else begin
                ev[i] = i < sz;
                if (i < sz) exp_e[i] = mq[i];
            end
        end
        chk("model_count", 64'(count), 64'(sz));
        chk("model_full", 64'(ibuf_full), 64'(mfull));
        chk("model_valid", 64'(out_valid), 64'(ev));
        for (int i = 0; i < DW; i++) begin
            if (ev[i]) begin
                chk($sformatf("model_slot%0d", i),
                    64'({out_inst[32*i +: 32], out_offset[4*i +: 4], out_fsq_idx[4*i +: 4], out_exc[2*i +: 2]}),
                    64'({exp_e[i].inst, exp_e[i].off, exp_e[i].fsq, exp_e[i].iam, exp_e[i].ipf}));
            end
        end
        if (flush) begin
            mq.delete();
        end else begin
            k = byp ? n : sz;
            if (k > DW) k = DW;
            if (!out_ready) k = 0;
            if (mwr) begin
                for (int i = 0; i < n; i++) begin
                    e = '{in_inst[32*i +: 32], in_offset[4*i +: 4], in_fsq_idx, in_ipf, in_iam};
                    mq.push_back(e);
                end
            end
            for (int i = 0; i < k; i++) void'(mq.pop_front());
        end
    endtask

    task automatic step(input int n, input logic [31:0] base, input logic fl, input logic rdy, input bit rnd);
        @(negedge clk);
        drive(n, base, fl, rdy, rnd);
        #1;
        check_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input int n, input logic fl, input logic rdy, input logic [31:0] base,
                                input int c, input logic f);
        vec_t v;
        v = '{n, fl, rdy, base, c, f};
        vt.push_back(v);
    endfunction

    initial begin
        rst = 1'b0;
        drive(0, 32'd0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_full", 64'(ibuf_full), 64'd0);
        chk("reset_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        add(3, 0, 0, 32'hA,    3, 0);
        add(0, 1, 0, 32'h0,    0, 0);
        add(8, 0, 0, 32'h100,  8, 0);
        add(8, 0, 0, 32'h200, 16, 0);
        add(8, 0, 0, 32'h300, 24, 0);
        add(1, 0, 0, 32'h400, 25, 1);
        add(8, 0, 0, 32'h500, 25, 1);
        add(0, 1, 0, 32'h0,    0, 0);
        add(8, 0, 0, 32'h600,  8, 0);
        add(4, 0, 0, 32'h700, 12, 0);
        add(5, 1, 0, 32'h800,  0, 0);
        add(3, 0, 0, 32'h900,  3, 0);
        add(3, 0, 0, 32'hA00,  6, 0);
        add(8, 0, 1, 32'hB00, 10, 0);
        add(0, 0, 1, 32'h0,    6, 0);
        add(0, 0, 1, 32'h0,    2, 0);
        add(0, 0, 1, 32'h0,    0, 0);
        add(0, 1, 0, 32'h0,    0, 0);
        add(8, 0, 0, 32'hC00,  8, 0);
        add(8, 0, 0, 32'hD00, 16, 0);
        add(8, 0, 0, 32'hE00, 24, 0);
        add(6, 0, 0, 32'hF00, 30, 1);
        add(0, 0, 1, 32'h0,   26, 1);
        add(0, 0, 1, 32'h0,   22, 0);
        add(0, 0, 1, 32'h0,   18, 0);
        add(0, 0, 1, 32'h0,   14, 0);
        add(0, 0, 1, 32'h0,   10, 0);
        add(0, 0, 1, 32'h0,    6, 0);
        add(0, 0, 1, 32'h0,    2, 0);
        add(0, 0, 1, 32'h0,    0, 0);
        add(8, 0, 0, 32'h1000, 8, 0);
        add(0, 0, 1, 32'h0,    4, 0);
        add(0, 0, 1, 32'h0,    0, 0);

        for (int k = 0; k < vt.size(); k++) begin
            step(vt[k].n, vt[k].base, vt[k].fl, vt[k].rdy, 1'b0);
            chk($sformatf("vec%0d_count", k), 64'(count), 64'(vt[k].exp_cnt));
            chk($sformatf("vec%0d_full", k), 64'(ibuf_full), 64'(vt[k].exp_full));
            if (k == 0) begin
                chk("first_valid", 64'(out_valid), 64'h7);
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("first_inst%0d", i), 64'(out_inst[32*i +: 32]), 64'(32'hA + 32'(i)));
                    chk($sformatf("first_fsq%0d", i), 64'(out_fsq_idx[4*i +: 4]), 64'd5);
                end
            end
            if (k == 11) begin
                chk("post_flush_slot0", 64'(out_inst[31:0]), 64'h900);
            end
        end

`ifdef IBUF_BYPASS_EN
        @(negedge clk);
        drive(6, 32'h2000, 1'b0, 1'b1, 1'b0);
        #1;
        chk("bypass_valid", 64'(out_valid), 64'hF);
        for (int i = 0; i < DW; i++) begin
            chk($sformatf("bypass_inst%0d", i), 64'(out_inst[32*i +: 32]), 64'(32'h2000 + 32'(i)));
        end
        check_cycle();
        @(posedge clk);
        #1;
        chk("bypass_count", 64'(count), 64'd2);
        @(negedge clk);
        drive(0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("bypass_rem0", 64'(out_inst[31:0]), 64'h2004);
        chk("bypass_rem1", 64'(out_inst[63:32]), 64'h2005);
        check_cycle();
        step(0, 32'd0, 1'b1, 1'b0, 1'b0);
`endif

        for (int c = 0; c < 600; c++) begin
            int n;
            n = ($urandom % 3 == 0) ? 0 : int'($urandom_range(1, 8));
            step(n, 32'd0, 1'($urandom % 25 == 0), 1'($urandom % 5 < 2), 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
